dem_mode_ctrl: RTL and testbench

Mode sequencer in front of the 18-element ISI/mismatch-shaping DEM core. It owns the core's ISI_SEL/MIS_SEL bypass controls, its loop-state clear, and its code input. On a mode-change request it performs a glitch-free switch: ramp the code to mid-scale, clear the loop filters, apply the new selects, warm up, then ramp back to the live code. In steady state it passes the live code through, clamped to the element range.

---
 rtl/dem_mode_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dem_mode_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dem_mode_ctrl.sv
// Mode sequencer for the 18-element ISI/mismatch-shaping DEM core.
// Passes the clamped live code through in RUN. On a mode change it ramps the
// code to mid-scale, clears the core loop filters, applies the new selects,
// warms up at code 0 and ramps back to the live code.
module dem_mode_ctrl #(
  parameter int V_W       = 6,
  parameter int V_MAX     = 18,
  parameter int RAMP_STEP = 4,
  parameter int MUTE_CYC  = 4,
  parameter int FLUSH_CYC = 3,
  parameter int WARM_CYC  = 8,
  parameter int RAMP_TO   = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic signed [V_W-1:0] v_in,
  input  logic                  mode_req,
  input  logic [1:0]            mode_new,
  output logic signed [V_W-1:0] v_out,
  output logic                  isi_sel,
  output logic                  mis_sel,
  output logic                  core_clr_n,
  output logic                  busy,
  output logic                  mode_ack,
  output logic                  mode_err,
  output logic [1:0]            cur_mode
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One extra bit so that clamping and stepping never wrap.
  localparam int IW    = V_W + 1;
  localparam int CMAX  = imax(imax(MUTE_CYC, FLUSH_CYC), imax(WARM_CYC, RAMP_TO));
  localparam int CNT_W = $clog2(CMAX) + 1;

  localparam logic signed [IW-1:0] VMAX_S = IW'(V_MAX);
  localparam logic signed [IW-1:0] VMIN_S = -VMAX_S;
  localparam logic signed [IW-1:0] STEP_S = IW'(RAMP_STEP);

  typedef enum logic [2:0] {S_RUN, S_MUTE, S_FLUSH, S_WARM, S_RAMP} state_t;

  function automatic logic signed [IW-1:0] clamp_v(input logic signed [IW-1:0] x);
    if (x > VMAX_S)      return VMAX_S;
    else if (x < VMIN_S) return VMIN_S;
    else                 return x;
  endfunction

  // Move at most RAMP_STEP toward tgt, landing exactly on it when close enough.
  function automatic logic signed [IW-1:0] step_to(input logic signed [IW-1:0] cur,
                                                   input logic signed [IW-1:0] tgt);
    logic signed [IW-1:0] diff;
    diff = tgt - cur;
    if (diff > STEP_S)       return cur + STEP_S;
    else if (diff < -STEP_S) return cur - STEP_S;
    else                     return tgt;
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           pend_q, pend_d;
  logic [1:0]           mode_q, mode_d;
  logic signed [V_W-1:0] v_q, v_d;
  logic                 isi_q, isi_d, mis_q, mis_d;
  logic                 clr_n_q, clr_n_d;
  logic                 ack_q, ack_d, err_q, err_d;

  logic signed [IW-1:0] vin_x, vc, vcur, vnext;

  assign vin_x = {v_in[V_W-1], v_in};
  assign vcur  = {v_q[V_W-1], v_q};
  assign vc    = clamp_v(vin_x);

  // Next-state, datapath and pulse outputs for the mode-switch sequence.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    v_d     = v_q;
    isi_d   = isi_q;
    mis_d   = mis_q;
    clr_n_d = clr_n_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    vnext   = '0;
    case (state_q)
      S_RUN: begin
        // Code is held at 0 during the clear that follows reset.
        clr_n_d = 1'b1;
        v_d     = clr_n_q ? vc[V_W-1:0] : '0;
        if (mode_req) begin
          if (mode_new == 2'b11) begin
            err_d = 1'b1;
          end else if (mode_new == mode_q) begin
            ack_d = 1'b1;
          end else begin
            pend_d  = mode_new;
            state_d = S_MUTE;
          end
        end
      end
      S_MUTE: begin
        vnext = step_to(vcur, '0);
        v_d   = vnext[V_W-1:0];
        // Leave after MUTE_CYC cycles in this state, and only once at 0.
        if (cnt_q >= CNT_W'(MUTE_CYC - 1) && v_q == '0) begin
          state_d = S_FLUSH;
          clr_n_d = 1'b0;
          isi_d   = (pend_q == 2'b01);
          mis_d   = (pend_q == 2'b10);
          mode_d  = pend_q;
        end
      end
      S_FLUSH: begin
        v_d = '0;
        if (cnt_q >= CNT_W'(FLUSH_CYC - 1)) begin
          clr_n_d = 1'b1;
          state_d = S_WARM;
        end
      end
      S_WARM: begin
        v_d = '0;
        if (cnt_q >= CNT_W'(WARM_CYC - 1)) state_d = S_RAMP;
      end
      S_RAMP: begin
        vnext = step_to(vcur, vc);
        // A live code that keeps moving away is caught by the timeout.
        if (vnext == vc || cnt_q >= CNT_W'(RAMP_TO - 1)) begin
          vnext   = vc;
          state_d = S_RUN;
          ack_d   = 1'b1;
        end
        v_d = vnext[V_W-1:0];
      end
      default: state_d = S_RUN;
    endcase
    cnt_d = (state_d != state_q) ? '0 : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
  end

  // State, counter and registered outputs; reset aborts any sequence.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      pend_q  <= '0;
      mode_q  <= '0;
      v_q     <= '0;
      isi_q   <= 1'b0;
      mis_q   <= 1'b0;
      clr_n_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      v_q     <= v_d;
      isi_q   <= isi_d;
      mis_q   <= mis_d;
      clr_n_q <= clr_n_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign v_out      = v_q;
  assign isi_sel    = isi_q;
  assign mis_sel    = mis_q;
  assign core_clr_n = clr_n_q;
  assign busy       = (state_q != S_RUN);
  assign mode_ack   = ack_q;
  assign mode_err   = err_q;
  assign cur_mode   = mode_q;

endmodule

// File: tb/tb_dem_mode_ctrl.sv
// Bench for dem_mode_ctrl: directed scenarios followed by randomized traffic,
// checked every cycle against a transaction-level model of the switch sequence.
module tb_dem_mode_ctrl;

  localparam int V_W       = 6;
  localparam int V_MAX     = 18;
  localparam int RAMP_STEP = 4;
  localparam int MUTE_CYC  = 4;
  localparam int FLUSH_CYC = 3;
  localparam int WARM_CYC  = 8;
  localparam int RAMP_TO   = 16;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic signed [V_W-1:0] v_in;
  logic                  mode_req;
  logic [1:0]            mode_new;
  logic signed [V_W-1:0] v_out;
  logic                  isi_sel, mis_sel, core_clr_n, busy, mode_ack, mode_err;
  logic [1:0]            cur_mode;

  dem_mode_ctrl #(
    .V_W(V_W), .V_MAX(V_MAX), .RAMP_STEP(RAMP_STEP), .MUTE_CYC(MUTE_CYC),
    .FLUSH_CYC(FLUSH_CYC), .WARM_CYC(WARM_CYC), .RAMP_TO(RAMP_TO)
  ) dut (
    .clk(clk), .rstn(rstn), .v_in(v_in), .mode_req(mode_req), .mode_new(mode_new),
    .v_out(v_out), .isi_sel(isi_sel), .mis_sel(mis_sel), .core_clr_n(core_clr_n),
    .busy(busy), .mode_ack(mode_ack), .mode_err(mode_err), .cur_mode(cur_mode)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Model of what the outputs should be after the current edge.
  int m_v, m_mode;
  bit m_clr, m_busy, m_ack, m_err;

  // Live-code source: 0 random, 1 fixed vfix, 2 toggle +/-V_MAX.
  int vsrc = 0;
  int vfix = 0;
  bit tog_ph = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clampi(input int x);
    if (x > V_MAX) return V_MAX;
    if (x < -V_MAX) return -V_MAX;
    return x;
  endfunction

  function automatic int stepi(input int c, input int t);
    if (t - c > RAMP_STEP) return c + RAMP_STEP;
    if (c - t > RAMP_STEP) return c - RAMP_STEP;
    return t;
  endfunction

  task automatic m_reset();
    m_v = 0; m_mode = 0; m_clr = 0; m_busy = 0; m_ack = 0; m_err = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply the next live code; return its clamped value.
  task automatic drive(output int vc);
    int x;
    logic signed [V_W-1:0] r;
    case (vsrc)
      1: x = vfix;
      2: begin tog_ph = ~tog_ph; x = tog_ph ? V_MAX : -V_MAX; end
      default: begin r = V_W'($urandom); x = int'(r); end
    endcase
    v_in = x[V_W-1:0];
    vc = clampi(x);
  endtask

  task automatic noise(input bit en);
    if (en) begin
      mode_req = 1'($urandom_range(0, 1));
      mode_new = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ":v_out"},      int'($signed(v_out)), m_v);
    chk({ph, ":isi_sel"},    int'(isi_sel),    int'(m_mode == 1));
    chk({ph, ":mis_sel"},    int'(mis_sel),    int'(m_mode == 2));
    chk({ph, ":cur_mode"},   int'(cur_mode),   m_mode);
    chk({ph, ":core_clr_n"}, int'(core_clr_n), int'(m_clr));
    chk({ph, ":busy"},       int'(busy),       int'(m_busy));
    chk({ph, ":mode_ack"},   int'(mode_ack),   int'(m_ack));
    chk({ph, ":mode_err"},   int'(mode_err),   int'(m_err));
  endtask

  // One steady-state cycle, optionally carrying a request.
  task automatic run_cycle(input bit req, input logic [1:0] nm, output bit acc);
    int vc;
    drive(vc);
    mode_req = req;
    mode_new = nm;
    acc = 1'b0; m_ack = 0; m_err = 0;
    m_v = m_clr ? vc : 0;
    m_clr = 1;
    if (req) begin
      if (nm == 2'b11) m_err = 1;
      else if (int'(nm) == m_mode) m_ack = 1;
      else acc = 1'b1;
    end
    m_busy = acc;
    tick();
    mode_req = 1'b0;
    check_all("run");
  endtask

  // Whole switch sequence after acceptance; abort fires an async reset in FLUSH.
  task automatic do_switch(input int pend, input bit nz, input bit abort);
    int vc, k, nv;
    m_ack = 0; m_err = 0;
    mode_req = 1'b0;
    k = 0;
    while (!(k >= MUTE_CYC - 1 && m_v == 0)) begin
      noise(nz); drive(vc);
      m_v = stepi(m_v, 0); k++;
      tick(); check_all("mute");
    end
    noise(nz); drive(vc);
    tick();
    m_clr = 0; m_mode = pend;
    check_all("mute_exit");
    if (abort) begin
      #2 rstn = 1'b0;
      #1;
      m_reset();
      mode_req = 1'b0;
      check_all("async_rst");
      return;
    end
    for (int i = 1; i < FLUSH_CYC; i++) begin
      if (nz) begin mode_req = 1'b1; mode_new = 2'b00; end
      drive(vc); tick(); check_all("flush");
    end
    noise(nz); drive(vc); tick();
    m_clr = 1;
    check_all("flush_exit");
    for (int i = 1; i < WARM_CYC; i++) begin
      noise(nz); drive(vc); tick(); check_all("warm");
    end
    noise(nz); drive(vc); tick(); check_all("warm_exit");
    for (int j = 0; j < RAMP_TO; j++) begin
      noise(nz); drive(vc);
      nv = stepi(m_v, vc);
      if (nv == vc || j == RAMP_TO - 1) begin
        m_v = vc; m_ack = 1; m_busy = 0;
        tick(); check_all("ramp_done");
        break;
      end
      m_v = nv;
      tick(); check_all("ramp");
    end
    mode_req = 1'b0;
  endtask

  initial begin
    bit acc;
    logic [1:0] nm;
    rstn = 1'b0; v_in = 7; mode_req = 1'b0; mode_new = 2'b00;
    m_reset();
    #2 check_all("reset");
    repeat (2) @(posedge clk);
    #1 check_all("reset_hold");
    @(negedge clk) rstn = 1'b1;

    // Reset release: clear lifts first, live code follows one edge later.
    vsrc = 1; vfix = 7;
    run_cycle(1'b0, 2'b00, acc);
    run_cycle(1'b0, 2'b00, acc);

    // Clamp.
    vfix = 25;  run_cycle(1'b0, 2'b00, acc);
    vfix = -32; run_cycle(1'b0, 2'b00, acc);
    vfix = -5;  run_cycle(1'b0, 2'b00, acc);

    // Full switch 00 -> 01 with a steady code of 10.
    vfix = 10;
    run_cycle(1'b1, 2'b01, acc);
    do_switch(1, 1'b0, 1'b0);
    run_cycle(1'b0, 2'b00, acc);

    // Illegal and same-mode requests.
    run_cycle(1'b1, 2'b11, acc);
    run_cycle(1'b1, 2'b01, acc);
    run_cycle(1'b0, 2'b00, acc);

    // Requests while busy, and ramp timeout with a toggling code.
    vsrc = 2;
    run_cycle(1'b1, 2'b10, acc);
    do_switch(2, 1'b1, 1'b0);
    run_cycle(1'b0, 2'b00, acc);

    // Asynchronous reset in the middle of FLUSH.
    vsrc = 0;
    run_cycle(1'b1, 2'b00, acc);
    do_switch(0, 1'b0, 1'b1);
    @(negedge clk) rstn = 1'b1;
    run_cycle(1'b0, 2'b00, acc);
    run_cycle(1'b0, 2'b00, acc);

    // Randomized traffic.
    repeat (150) begin
      vsrc = ($urandom_range(0, 3) == 0) ? 2 : 0;
      nm = 2'($urandom_range(0, 3));
      run_cycle($urandom_range(0, 4) == 0, nm, acc);
      if (acc) do_switch(int'(nm), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
